vram_write_scheduler: RTL

Arbitrates the single VRAM port between the VGA pixel-fetch path and an update writer (pattern generator or host logic). Write requests are buffered in a small FIFO and drained only during vertical blanking, so the display read path never loses a cycle in the visible region. Consumes the shared `H_counter`/`V_counter` timing (640x480, 4 clocks per pixel: H 0..3199, V 0..520) and emits a frame-boundary tick for downstream animation logic.

---
 rtl/vram_write_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler
//
// Shares the single VRAM port between the VGA pixel-fetch path and an
// update writer. Write requests go into a small FIFO at any time. They are
// drained only inside the vertical-blanking write window, so the display
// read path keeps every cycle of the visible region. The block also emits a
// one-cycle frame-boundary tick.
//
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   H_counter        : horizontal position, 0..3199 (4 clocks per pixel)
//   V_counter        : vertical line, 0..520
//   pix_addr         : display-path read address
//   wr_valid/ready   : write-request handshake (wr_addr, wr_data)
//   mem_addr/we/wdata: registered VRAM port
//   frame_tick       : one-cycle pulse after the last clock of a frame
//   pending          : FIFO occupancy
//   sched_state      : 0 DISPLAY, 1 BLANK_IDLE, 2 WRITE
module vram_write_scheduler #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [11:0]              H_counter,
    input  logic [9:0]               V_counter,
    input  logic [ADDR_W-1:0]        pix_addr,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     frame_tick,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [1:0]               sched_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_DISPLAY    = 2'd0,
        S_BLANK_IDLE = 2'd1,
        S_WRITE      = 2'd2
    } state_t;

    state_t state_p1;
    state_t state_next;

    // FIFO storage is pure datapath: entries are qualified by the pointers
    // and count, so it carries no reset.
    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_p1;
    logic [PTR_W-1:0]  wr_ptr_p1;
    logic [PTR_W:0]    count_p1;

    logic [ADDR_W-1:0] mem_addr_p1;
    logic              vld_p1;
    logic [DATA_W-1:0] mem_wdata_p1;
    logic              frame_tick_p1;

    logic win_p0;
    logic push_p0;
    logic pop_p0;
    logic last_clk_p0;

    // Stage p0: window decode and FIFO handshakes from the current counters.
    // The final 8 clocks of line 520 stay closed so display prefetch owns them.
    assign win_p0      = (V_counter >= 10'd480) &&
                         !(V_counter == 10'd520 && H_counter >= 12'd3192);
    assign last_clk_p0 = (V_counter == 10'd520) && (H_counter == 12'd3199);

    // Ready comes from the registered count only, so a full FIFO stays
    // not-ready even in a cycle that pops.
    assign wr_ready = (count_p1 != FULL_COUNT);
    assign push_p0  = wr_valid && wr_ready;
    // Popping from the registered count means a push into an empty FIFO is
    // visible to the drain logic one cycle later.
    assign pop_p0   = win_p0 && (count_p1 != '0);

    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_addr[wr_ptr_p1] <= wr_addr;
            fifo_data[wr_ptr_p1] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_p1 <= '0;
            wr_ptr_p1 <= '0;
            count_p1  <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
            end
            if (pop_p0) begin
                rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            end
            case ({push_p0, pop_p0})
                2'b10:   count_p1 <= count_p1 + (PTR_W+1)'(1);
                2'b01:   count_p1 <= count_p1 - (PTR_W+1)'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    always_comb begin
        state_next = S_DISPLAY;
        if (pop_p0) begin
            state_next = S_WRITE;
        end else if (win_p0) begin
            state_next = S_BLANK_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_p1 <= S_DISPLAY;
        end else begin
            state_p1 <= state_next;
        end
    end

    // Stage p1: registered VRAM port and frame tick.
    // Write data holds its last value on read cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_p1   <= '0;
            vld_p1        <= 1'b0;
            mem_wdata_p1  <= '0;
            frame_tick_p1 <= 1'b0;
        end else begin
            frame_tick_p1 <= last_clk_p0;
            vld_p1        <= pop_p0;
            if (pop_p0) begin
                mem_addr_p1  <= fifo_addr[rd_ptr_p1];
                mem_wdata_p1 <= fifo_data[rd_ptr_p1];
            end else begin
                mem_addr_p1  <= pix_addr;
            end
        end
    end

    assign mem_addr    = mem_addr_p1;
    assign mem_we      = vld_p1;
    assign mem_wdata   = mem_wdata_p1;
    assign frame_tick  = frame_tick_p1;
    assign pending     = count_p1;
    assign sched_state = state_p1;

endmodule
